complex_div_iter: RTL

- Sequential 18-bit signed complex divider: q = a / b, computed as ((ar*br + ai*bi) + j(ai*br - ar*bi)) / (br^2 + bi^2).
- Inverse companion to the team's 18-bit complex multiplier; shares the same operand format and sits beside it in the DSP datapath.
- Three multiply/prepare cycles, then restoring division producing one quotient bit per cycle on both components in parallel.
- Start/busy/done handshake.

---
 rtl/complex_div_iter_pkg.sv | 29 ++
 rtl/cdiv_restoring_core.sv | 59 +++++
 rtl/complex_div_iter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/complex_div_iter_pkg.sv
// Shared definitions for the complex divider. The default widths match the
// complex multiplier that sits beside it in the DSP datapath.
package complex_div_iter_pkg;

  localparam int unsigned IN_W_DEF      = 18;
  localparam int unsigned OUT_W_DEF     = 18;
  localparam int unsigned FRAC_BITS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_PREP = 2'd2,
    ST_DIV  = 2'd3
  } state_t;

  // Saturation value for a w-bit signed result:
  // neg=0 gives 2^(w-1)-1 and neg=1 gives -2^(w-1), in the low w bits.
  function automatic logic [63:0] sat_const(input logic neg, input int unsigned w);
    logic [63:0] one;
    logic [63:0] max_pos;
    one     = 64'd1;
    max_pos = (one << (w - 1)) - one;
    if (neg) begin
      return ~max_pos;
    end
    return max_pos;
  endfunction

endpackage

// File: rtl/cdiv_restoring_core.sv
// Unsigned iterative restoring divider. It produces one quotient bit per step,
// MSB first, with the bit position supplied by the shared counter.
// The quo output already includes the decision of the current step, so the
// parent can latch the final quotient on the same edge as the last step.
module cdiv_restoring_core #(
  parameter int unsigned NUM_W = 53,
  parameter int unsigned DEN_W = 36,
  parameter int unsigned Q_W   = 18,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] cnt,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] den,
  output logic [Q_W-1:0]   quo
);

  localparam int unsigned SH_W = NUM_W + Q_W;

  logic [NUM_W-1:0] rem;
  logic [Q_W-1:0]   q_acc;
  logic [SH_W-1:0]  den_sh;
  logic [Q_W-1:0]   bit_mask;
  logic             fit;
  logic [NUM_W-1:0] rem_next;
  logic [Q_W-1:0]   q_next;

  // Trial subtraction of den<<cnt against the running remainder.
  always_comb begin
    den_sh   = SH_W'(den) << cnt;
    bit_mask = {{(Q_W-1){1'b0}}, 1'b1} << cnt;
    fit      = SH_W'(rem) >= den_sh;
    rem_next = rem;
    q_next   = q_acc;
    if (step && fit) begin
      rem_next = rem - den_sh[NUM_W-1:0];
      q_next   = q_acc | bit_mask;
    end
    quo = q_next;
  end

  // Remainder and quotient accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      q_acc <= '0;
    end else if (load) begin
      rem   <= dividend;
      q_acc <= '0;
    end else if (step) begin
      rem   <= rem_next;
      q_acc <= q_next;
    end
  end

endmodule

// File: rtl/complex_div_iter.sv
// Sequential signed complex divider q = a / b.
// Flow: capture operands, register the four cross products, form the
// numerators/denominator and saturation flags, then run OUT_W restoring
// division steps on both components in parallel.
module complex_div_iter
  import complex_div_iter_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [IN_W-1:0]  a_real,
  input  logic signed [IN_W-1:0]  a_img,
  input  logic signed [IN_W-1:0]  b_real,
  input  logic signed [IN_W-1:0]  b_img,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] q_real,
  output logic signed [OUT_W-1:0] q_img,
  output logic                    ovf,
  output logic                    dbz
);

  localparam int unsigned PROD_W = 2 * IN_W;
  localparam int unsigned NUM_W  = PROD_W + 1;
  localparam int unsigned SCL_W  = NUM_W + FRAC_BITS;
  localparam int unsigned CMP_W  = SCL_W + OUT_W;
  localparam int unsigned CNT_W  = $clog2(OUT_W);

  localparam logic [OUT_W-1:0] MAX_POS = OUT_W'(sat_const(1'b0, OUT_W));
  localparam logic [OUT_W-1:0] MIN_NEG = OUT_W'(sat_const(1'b1, OUT_W));
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(OUT_W - 1);

  state_t state;
  state_t state_next;

  logic signed [IN_W-1:0]   ar, ai, br, bi;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ir, p_ri;

  logic signed [NUM_W-1:0]  num_r, num_i;
  logic signed [PROD_W-1:0] sq_r, sq_i;
  logic [PROD_W-1:0]        den;
  logic [NUM_W-1:0]         mag_r, mag_i;
  logic [SCL_W-1:0]         scl_r, scl_i;
  logic [CMP_W-1:0]         den_lim;
  logic                     ovf_r_d, ovf_i_d;

  logic                     neg_r, neg_i;
  logic                     ovf_r_q, ovf_i_q;
  logic                     dbz_q;
  logic [PROD_W-1:0]        den_q;
  logic [CNT_W-1:0]         cnt;

  logic                     load;
  logic                     step;
  logic                     last;
  logic [OUT_W-1:0]         quo_r, quo_i;

  logic                     busy_d;
  logic signed [OUT_W-1:0]  res_r, res_i;
  logic                     ovf_d;

  assign load = (state == ST_PREP);
  assign step = (state == ST_DIV);
  assign last = step && (cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fixed sequence, DIV ends when the bit counter hits 0.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_MULT;
      ST_MULT: state_next = ST_PREP;
      ST_PREP: state_next = ST_DIV;
      ST_DIV:  if (cnt == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Numerators, denominator, magnitudes and per-component saturation test.
  always_comb begin
    num_r   = NUM_W'(p_rr) + NUM_W'(p_ii);
    num_i   = NUM_W'(p_ir) - NUM_W'(p_ri);
    sq_r    = PROD_W'(br) * PROD_W'(br);
    sq_i    = PROD_W'(bi) * PROD_W'(bi);
    den     = $unsigned(sq_r + sq_i);
    mag_r   = num_r[NUM_W-1] ? $unsigned(-num_r) : $unsigned(num_r);
    mag_i   = num_i[NUM_W-1] ? $unsigned(-num_i) : $unsigned(num_i);
    scl_r   = {mag_r, {FRAC_BITS{1'b0}}};
    scl_i   = {mag_i, {FRAC_BITS{1'b0}}};
    den_lim = CMP_W'(den) << (OUT_W - 1);
    ovf_r_d = CMP_W'(scl_r) >= den_lim;
    ovf_i_d = CMP_W'(scl_i) >= den_lim;
  end

  // Output decode: result selection by priority dbz > saturation > quotient.
  always_comb begin
    busy_d = (state_next != ST_IDLE);
    res_r  = '0;
    res_i  = '0;
    ovf_d  = 1'b0;
    if (!dbz_q) begin
      ovf_d = ovf_r_q | ovf_i_q;
      if (ovf_r_q)    res_r = neg_r ? MIN_NEG : MAX_POS;
      else if (neg_r) res_r = -quo_r;
      else            res_r = quo_r;
      if (ovf_i_q)    res_i = neg_i ? MIN_NEG : MAX_POS;
      else if (neg_i) res_i = -quo_i;
      else            res_i = quo_i;
    end
  end

  // Operand capture, product registers, prepare-stage flags and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar      <= '0;
      ai      <= '0;
      br      <= '0;
      bi      <= '0;
      p_rr    <= '0;
      p_ii    <= '0;
      p_ir    <= '0;
      p_ri    <= '0;
      neg_r   <= 1'b0;
      neg_i   <= 1'b0;
      ovf_r_q <= 1'b0;
      ovf_i_q <= 1'b0;
      dbz_q   <= 1'b0;
      den_q   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ar <= a_real;
            ai <= a_img;
            br <= b_real;
            bi <= b_img;
          end
        end
        ST_MULT: begin
          p_rr <= PROD_W'(ar) * PROD_W'(br);
          p_ii <= PROD_W'(ai) * PROD_W'(bi);
          p_ir <= PROD_W'(ai) * PROD_W'(br);
          p_ri <= PROD_W'(ar) * PROD_W'(bi);
        end
        ST_PREP: begin
          neg_r   <= num_r[NUM_W-1];
          neg_i   <= num_i[NUM_W-1];
          ovf_r_q <= ovf_r_d;
          ovf_i_q <= ovf_i_d;
          dbz_q   <= (den == '0);
          den_q   <= den;
          cnt     <= CNT_TOP;
        end
        ST_DIV: begin
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; results change only on the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      q_real <= '0;
      q_img  <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= last;
      if (last) begin
        q_real <= res_r;
        q_img  <= res_i;
        ovf    <= ovf_d;
        dbz    <= dbz_q;
      end
    end
  end

  cdiv_restoring_core #(
    .NUM_W (SCL_W),
    .DEN_W (PROD_W),
    .Q_W   (OUT_W),
    .CNT_W (CNT_W)
  ) u_core_real (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .cnt      (cnt),
    .dividend (scl_r),
    .den      (den_q),
    .quo      (quo_r)
  );

  cdiv_restoring_core #(
    .NUM_W (SCL_W),
    .DEN_W (PROD_W),
    .Q_W   (OUT_W),
    .CNT_W (CNT_W)
  ) u_core_img (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .cnt      (cnt),
    .dividend (scl_i),
    .den      (den_q),
    .quo      (quo_i)
  );

endmodule
